ring_vc_arbiter: RTL and testbench

- Output-port scheduler for the ring router; one instance sits on each of the cw, ccw and pe output links.
- Shares one output link between up to NREQ input-side requesters, such as the cw, ccw and pe input buffers.
- Holds one single-entry buffer per virtual channel (even, odd) and sequences them by the global polarity bit.
- On each cycle, the VC matching polarity transmits downstream while the other VC is refilled through round-robin arbitration.

---
 rtl/ring_vc_arbiter_if.sv | 23 ++
 rtl/ring_vc_arbiter.sv | 103 ++++++++++
 tb/tb_ring_vc_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ring_vc_arbiter_if.sv
// Requester-side and downstream-link signals of one ring output port.
// The link data bus is called link_data because "do" is a reserved word.
interface ring_vc_arbiter_if #(
   parameter int unsigned NREQ = 3,
   parameter int unsigned DW   = 64
);
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    grant;
   logic               so;
   logic [DW-1:0]      link_data;
   logic               ro;

   modport master (
      output req, req_data, ro,
      input  grant, so, link_data
   );

   modport slave (
      input  req, req_data, ro,
      output grant, so, link_data
   );
endinterface

// File: rtl/ring_vc_arbiter.sv
// Two-VC output scheduler: the polarity VC drains to the link while the other VC refills by round robin.
// Optional hop-field decrement on capture: define RING_VC_ARB_HOP_SHIFT_EN.
module ring_vc_arbiter #(
   parameter int unsigned NREQ   = 3,
   parameter int unsigned DW     = 64,
   parameter int unsigned SCNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              polarity,
   ring_vc_arbiter_if.slave  bus,
   output logic              full_even,
   output logic              full_odd,
   output logic [SCNT_W-1:0] stall_cnt
);

   localparam int unsigned      PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PTR_W-1:0] LAST   = PTR_W'(NREQ - 1);
   localparam logic [PTR_W:0]   NREQ_X = (PTR_W + 1)'(NREQ);

   logic [DW-1:0]    buf_even, buf_odd;
   logic             v_even, v_odd;
   logic [PTR_W-1:0] ptr_even, ptr_odd;

   logic             fill_v;
   logic [PTR_W-1:0] fill_ptr;
   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] idx;
   logic             found;
   logic [PTR_W-1:0] win, win_next;
   logic [DW-1:0]    raw, cap;
   logic             send;

   // Round-robin search from the fill VC's pointer, wrapping at NREQ-1
   always_comb begin
      fill_v   = polarity ? v_even : v_odd;
      fill_ptr = polarity ? ptr_even : ptr_odd;
      sum      = '0;
      idx      = '0;
      found    = 1'b0;
      win      = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         sum = {1'b0, fill_ptr} + (PTR_W + 1)'(k);
         if (sum >= NREQ_X) sum = sum - NREQ_X;
         idx = PTR_W'(sum);
         if (!fill_v && !found && bus.req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      win_next = (win == LAST) ? '0 : win + 1'b1;
   end

   // Winner's payload, with the hop field halved when the feature is built in
   always_comb begin
      raw = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (win == PTR_W'(k)) raw = bus.req_data[k*DW +: DW];
      end
      cap = raw;
`ifdef RING_VC_ARB_HOP_SHIFT_EN
      cap[25:18] = raw[25:18] >> 1;
`endif
   end

   assign send          = polarity ? v_odd : v_even;
   assign bus.so        = send;
   assign bus.link_data = !send ? '0 : (polarity ? buf_odd : buf_even);
   assign bus.grant     = (found && reset) ? (NREQ'(1) << win) : '0;
   assign full_even     = v_even;
   assign full_odd      = v_odd;

   // Tx VC and fill VC always differ, so each buffer sees at most one of drain/load per edge
   always_ff @(posedge clk) begin
      if (!reset) begin
         buf_even  <= '0;
         buf_odd   <= '0;
         v_even    <= 1'b0;
         v_odd     <= 1'b0;
         ptr_even  <= '0;
         ptr_odd   <= '0;
         stall_cnt <= '0;
      end else begin
         if (polarity) begin
            if (v_odd && bus.ro) v_odd <= 1'b0;
            if (found) begin
               buf_even <= cap;
               v_even   <= 1'b1;
               ptr_even <= win_next;
            end
         end else begin
            if (v_even && bus.ro) v_even <= 1'b0;
            if (found) begin
               buf_odd <= cap;
               v_odd   <= 1'b1;
               ptr_odd <= win_next;
            end
         end
         if (send && !bus.ro && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ring_vc_arbiter.sv
// Directed bench for ring_vc_arbiter: stimulus queues expected grants/packets, a negedge monitor checks them.
module tb_ring_vc_arbiter;

   localparam int unsigned NREQ   = 3;
   localparam int unsigned DW     = 64;
   localparam int unsigned SCNT_W = 16;

   logic              clk;
   logic              reset;
   logic              polarity;
   logic              full_even, full_odd;
   logic [SCNT_W-1:0] stall_cnt;

   ring_vc_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

   ring_vc_arbiter #(.NREQ(NREQ), .DW(DW), .SCNT_W(SCNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .polarity  (polarity),
      .bus       (bus),
      .full_even (full_even),
      .full_odd  (full_odd),
      .stall_cnt (stall_cnt)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [2:0]    exp_grant[$];
   logic [DW-1:0] exp_pkt[$];
   logic [DW-1:0] dnext[3];
   logic [DW-1:0] d[3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] hop(input logic [DW-1:0] x);
      logic [DW-1:0] y;
      y = x;
`ifdef RING_VC_ARB_HOP_SHIFT_EN
      y[25:18] = {1'b0, x[25:19]};
`endif
      return y;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock cycle: inputs applied just after the edge, returns at the following negedge
   task automatic cyc(input logic r, input logic p, input logic [2:0] rq, input logic o);
      @(posedge clk);
      #1;
      reset        = r;
      polarity     = p;
      bus.req      = rq;
      bus.ro       = o;
      bus.req_data = {dnext[2], dnext[1], dnext[0]};
      @(negedge clk);
   endtask

   // Monitor: every grant and every accepted link transfer must match the queued expectation
   always @(negedge clk) begin
      if (bus.grant !== 3'b000) begin
         if (exp_grant.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_grant: got %b, expected 000", bus.grant);
         end else begin
            chk("grant", DW'(bus.grant), DW'(exp_grant.pop_front()));
         end
      end
      if (reset === 1'b1 && bus.so === 1'b1 && bus.ro === 1'b1) begin
         if (exp_pkt.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_send: got %h, expected no send", bus.link_data);
         end else begin
            chk("link_data", bus.link_data, exp_pkt.pop_front());
         end
      end
   end

   initial begin
      reset        = 1'b0;
      polarity     = 1'b0;
      bus.req      = '0;
      bus.ro       = 1'b1;
      bus.req_data = '0;
      for (int i = 0; i < 3; i++) dnext[i] = '0;

      // Reset with all requesters active: nothing granted, everything idle
      repeat (3) cyc(1'b0, 1'b0, 3'b111, 1'b1);
      chk("rst_so", DW'(bus.so), '0);
      chk("rst_do", bus.link_data, '0);
      chk("rst_full_even", DW'(full_even), '0);
      chk("rst_full_odd", DW'(full_odd), '0);
      chk("rst_stall", DW'(stall_cnt), '0);
      repeat (2) begin
         cyc(1'b1, 1'b1, 3'b000, 1'b1);
         chk("idle_so", DW'(bus.so), '0);
         chk("idle_full_odd", DW'(full_odd), '0);
      end

      // Single packet through the odd VC
      dnext[0] = 64'h0000_0000_0040_0000;
      exp_grant.push_back(3'b001);
      cyc(1'b1, 1'b0, 3'b001, 1'b1);
      exp_pkt.push_back(hop(64'h0000_0000_0040_0000));
      cyc(1'b1, 1'b1, 3'b000, 1'b1);
      chk("single_full_odd", DW'(full_odd), 64'd1);
      chk("single_so", DW'(bus.so), 64'd1);
      cyc(1'b1, 1'b0, 3'b000, 1'b1);
      chk("single_drained", DW'(full_odd), '0);

      // Round robin on odd-VC fill cycles, after a reset to zero the pointers
      d[0] = 64'h0123_4567_89AB_CDEF;
      d[1] = 64'hFEDC_BA98_7654_3210;
      d[2] = 64'h0000_FFFF_03FC_0000;
      for (int i = 0; i < 3; i++) dnext[i] = d[i];
      cyc(1'b0, 1'b0, 3'b111, 1'b1);
      for (int k = 0; k < 4; k++) begin
         exp_grant.push_back(3'b001 << (k % 3));
         cyc(1'b1, 1'b0, 3'b111, 1'b1);
         exp_pkt.push_back(hop(d[k % 3]));
         cyc(1'b1, 1'b1, 3'b000, 1'b1);
      end
      // Pointer now at 1: requesters 0 and 2 active, 2 must win
      exp_grant.push_back(3'b100);
      cyc(1'b1, 1'b0, 3'b101, 1'b1);
      exp_pkt.push_back(hop(d[2]));
      cyc(1'b1, 1'b1, 3'b000, 1'b1);

      // Backpressure: odd buffer held for 5 odd cycles, no odd grant meanwhile
      exp_grant.push_back(3'b001);
      cyc(1'b1, 1'b0, 3'b001, 1'b1);
      for (int s = 1; s <= 5; s++) begin
         cyc(1'b1, 1'b1, 3'b000, 1'b0);
         chk("stall_so", DW'(bus.so), 64'd1);
         chk("stall_do", bus.link_data, hop(d[0]));
         cyc(1'b1, 1'b0, 3'b010, 1'b0);
         chk("stall_cnt", DW'(stall_cnt), DW'(s));
         chk("stall_full_odd", DW'(full_odd), 64'd1);
      end
      exp_pkt.push_back(hop(d[0]));
      cyc(1'b1, 1'b1, 3'b000, 1'b1);
      exp_grant.push_back(3'b010);
      cyc(1'b1, 1'b0, 3'b010, 1'b1);
      exp_pkt.push_back(hop(d[1]));
      cyc(1'b1, 1'b1, 3'b000, 1'b1);
      chk("stall_cnt_hold", DW'(stall_cnt), 64'd5);

      // Both VCs streaming: one new packet per cycle, one delivered per cycle
      for (int t = 0; t <= 20; t++) begin
         logic [2:0] oh;
         oh = (t < 20) ? (3'b001 << (t % 3)) : 3'b000;
         if (t < 20) begin
            dnext[t % 3] = {16'hBEEF, 16'(t), 32'(t) * 32'h0004_1001};
            exp_grant.push_back(oh);
            exp_pkt.push_back(hop(dnext[t % 3]));
         end
         cyc(1'b1, 1'(t % 2), oh, 1'b1);
         if (t >= 1) chk("stream_so", DW'(bus.so), 64'd1);
      end

      // Reset mid-operation with both buffers full
      dnext[0] = 64'hAAAA_0000_0000_0001;
      dnext[1] = 64'hBBBB_0000_0000_0002;
      dnext[2] = 64'hCCCC_0000_0000_0003;
      exp_grant.push_back(3'b001);
      cyc(1'b1, 1'b0, 3'b001, 1'b0);
      exp_grant.push_back(3'b010);
      cyc(1'b1, 1'b1, 3'b010, 1'b0);
      cyc(1'b0, 1'b0, 3'b111, 1'b0);
      chk("mid_full_even_pre", DW'(full_even), 64'd1);
      chk("mid_full_odd_pre", DW'(full_odd), 64'd1);
      exp_grant.push_back(3'b010);
      cyc(1'b1, 1'b1, 3'b110, 1'b1);
      chk("mid_full_even", DW'(full_even), '0);
      chk("mid_full_odd", DW'(full_odd), '0);
      chk("mid_so", DW'(bus.so), '0);
      chk("mid_do", bus.link_data, '0);
      chk("mid_stall", DW'(stall_cnt), '0);
      exp_pkt.push_back(hop(dnext[1]));
      exp_grant.push_back(3'b001);
      cyc(1'b1, 1'b0, 3'b011, 1'b1);
      exp_pkt.push_back(hop(dnext[0]));
      cyc(1'b1, 1'b1, 3'b000, 1'b1);
      cyc(1'b1, 1'b0, 3'b000, 1'b1);

      chk("grants_outstanding", DW'(exp_grant.size()), '0);
      chk("packets_outstanding", DW'(exp_pkt.size()), '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
